// File: rtl/vend_seq_ctrl.sv
// rtl/vend_seq_ctrl.sv - coin vending sequencer: credit, dispense handshake, change return
// Coins are edge-detected on registered sensor levels; every output is a flop.
module vend_seq_ctrl #(
  parameter int PRICE_A    = 15,
  parameter int PRICE_B    = 20,
  parameter int MAX_CREDIT = 30,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       cancel,
  output logic       disp_req,
  output logic       disp_item,
  input  logic       disp_done,
  output logic       chg_pulse,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      PRICE_A_W = 6'(PRICE_A);
  localparam logic [5:0]      PRICE_B_W = 6'(PRICE_B);
  localparam logic [6:0]      MAX_W     = 7'(MAX_CREDIT);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [5:0]      COIN_STEP = 6'd5;

  state_t        state_q, state_d;
  logic [5:0]    credit_q, credit_d;
  logic          disp_req_q, disp_req_d;
  logic          disp_item_q, disp_item_d;
  logic          chg_pulse_q, chg_pulse_d;
  logic          coin_reject_q, coin_reject_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          c5_lvl_q, c5_lvl_d, c10_lvl_q, c10_lvl_d;
  logic          c5_arm_q, c5_arm_d, c10_arm_q, c10_arm_d;

  logic       e5, e10, coin_evt, coin_both, coin_ok;
  logic       sel_a_ok, sel_b_ok;
  logic [6:0] coin_amt, credit_sum;

  // A sensor only arms once it has been seen low, so a level held across reset never counts.
  assign e5         = coin_5 & ~c5_lvl_q & c5_arm_q;
  assign e10        = coin_10 & ~c10_lvl_q & c10_arm_q;
  assign coin_evt   = e5 | e10;
  assign coin_both  = e5 & e10;
  assign coin_amt   = e10 ? 7'd10 : 7'd5;
  assign credit_sum = {1'b0, credit_q} + coin_amt;
  assign coin_ok    = coin_evt & ~coin_both & (credit_sum <= MAX_W);
  assign sel_a_ok   = sel_a & (credit_q >= PRICE_A_W);
  assign sel_b_ok   = ~sel_a & sel_b & (credit_q >= PRICE_B_W);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = disp_req_q;
    disp_item_d   = disp_item_q;
    chg_pulse_d   = 1'b0;
    coin_reject_d = 1'b0;
    tmo_d         = tmo_q;
    c5_lvl_d      = coin_5;
    c10_lvl_d     = coin_10;
    c5_arm_d      = c5_arm_q | ~coin_5;
    c10_arm_d     = c10_arm_q | ~coin_10;

    unique case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = credit_sum[5:0];
          state_d  = S_CREDIT;
          tmo_d    = '0;
        end else begin
          coin_reject_d = coin_evt;
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          coin_reject_d = coin_evt;
          chg_pulse_d   = 1'b1;
          tmo_d         = '0;
          state_d       = S_CHANGE;
        end else if (sel_a_ok || sel_b_ok) begin
          coin_reject_d = coin_evt;
          credit_d      = credit_q - (sel_a_ok ? PRICE_A_W : PRICE_B_W);
          disp_item_d   = sel_b_ok;
          disp_req_d    = 1'b1;
          tmo_d         = '0;
          state_d       = S_DISPENSE;
        end else if (coin_ok) begin
          credit_d = credit_sum[5:0];
          tmo_d    = '0;
        end else begin
          coin_reject_d = coin_evt;
          if (tmo_q == TMO_LAST) begin
            chg_pulse_d = 1'b1;
            tmo_d       = '0;
            state_d     = S_CHANGE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_DISPENSE: begin
        coin_reject_d = coin_evt;
        if (disp_done) begin
          disp_req_d = 1'b0;
          if (credit_q != 6'd0) begin
            chg_pulse_d = 1'b1;
            state_d     = S_CHANGE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        coin_reject_d = coin_evt;
        // Credit drops at the end of each ejecting cycle, so it reads non-zero while chg_pulse is high.
        if (chg_pulse_q) begin
          credit_d = credit_q - COIN_STEP;
        end else if (credit_q == 6'd0) begin
          state_d = S_IDLE;
        end else begin
          chg_pulse_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      disp_item_q   <= 1'b0;
      chg_pulse_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      tmo_q         <= '0;
      c5_lvl_q      <= 1'b0;
      c10_lvl_q     <= 1'b0;
      c5_arm_q      <= 1'b0;
      c10_arm_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      disp_item_q   <= disp_item_d;
      chg_pulse_q   <= chg_pulse_d;
      coin_reject_q <= coin_reject_d;
      tmo_q         <= tmo_d;
      c5_lvl_q      <= c5_lvl_d;
      c10_lvl_q     <= c10_lvl_d;
      c5_arm_q      <= c5_arm_d;
      c10_arm_q     <= c10_arm_d;
    end
  end

  assign state       = state_q;
  assign credit      = credit_q;
  assign disp_req    = disp_req_q;
  assign disp_item   = disp_item_q;
  assign chg_pulse   = chg_pulse_q;
  assign coin_reject = coin_reject_q;

endmodule

// File: doc/vend_seq_ctrl.md
VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 SHALL have parameter PRICE_A, 15, price of item A in rupees (multiple of 5, 5..MAX_CREDIT).
REQ-002 SHALL have parameter PRICE_B, 20, price of item B in rupees (multiple of 5, 5..MAX_CREDIT).
REQ-003 SHALL have parameter MAX_CREDIT, 30, credit ceiling in rupees (multiple of 5, <=60).
REQ-004 SHALL have parameter TIMEOUT, 16, idle cycles in CREDIT before auto-refund (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port coin_5  input  1  5-rupee coin sensor level.
REQ-008 SHALL have port coin_10  input  1  10-rupee coin sensor level.
REQ-009 SHALL have port sel_a / sel_b  input  1 each  item select requests, level.
REQ-010 SHALL have port cancel  input  1  refund request, level.
REQ-011 SHALL have port disp_req  output  1  dispense request to dispenser mechanism.
REQ-012 SHALL have port disp_item  output  1  item being dispensed (0=A, 1=B), valid while disp_req=1.
REQ-013 SHALL have port disp_done  input  1  dispenser completion, one-cycle pulse.
REQ-014 SHALL have port chg_pulse  output  1  one 5-rupee coin ejected per high cycle.
REQ-015 SHALL have port coin_reject  output  1  one-cycle pulse: inserted coin returned, not credited.
REQ-016 SHALL have port credit  output  6  current credit in rupees.
REQ-017 SHALL have port state  output  2  FSM state: 0 IDLE, 1 CREDIT, 2 DISPENSE, 3 CHANGE.

Function
REQ-018 Coins SHALL be detected on 0->1 transition of the registered sensor level; a held level counts once.
REQ-019 Coin events accepted only in IDLE/CREDIT; in DISPENSE/CHANGE any coin event -> coin_reject pulse next cycle, credit unchanged.
REQ-020 Accepted coin: credit += 5 or 10 next cycle; IDLE -> CREDIT.
REQ-021 Coin making credit exceed MAX_CREDIT SHALL be rejected (coin_reject pulse, credit unchanged).
REQ-022 coin_5 and coin_10 edges in same cycle: both rejected, single coin_reject pulse.
REQ-023 In CREDIT, sel_a (priority over sel_b) with credit >= price: credit -= price, disp_item set, disp_req=1, -> DISPENSE, all next cycle.
REQ-024 Select with insufficient credit SHALL be ignored; no state change.
REQ-025 Coin edge in same cycle as a valid select SHALL be rejected.
REQ-026 disp_req SHALL stay high through DISPENSE until the cycle after disp_done; then -> CHANGE if credit>0, else IDLE.
REQ-027 disp_done outside DISPENSE SHALL be ignored.
REQ-028 cancel in CREDIT (overrides select) -> CHANGE; cancel in other states ignored.
REQ-029 Timeout counter SHALL clear on every accepted coin or entry to CREDIT, count each CREDIT cycle; at TIMEOUT -> CHANGE.
REQ-030 In CHANGE chg_pulse SHALL alternate 1,0,1,0... starting first CHANGE cycle; each high cycle credit -= 5; credit reaching 0 -> IDLE on the following cycle.
REQ-031 credit SHALL never exceed MAX_CREDIT nor underflow; chg_pulse never asserted with credit=0.
REQ-032 Outputs SHALL be registered; one-cycle latency from input event to response.

Reset
REQ-033 reset=1 SHALL immediately force state=IDLE, credit=0, disp_req=0, disp_item=0, chg_pulse=0, coin_reject=0, timeout counter=0, coin edge registers=0.
REQ-034 Reset mid-DISPENSE or mid-CHANGE SHALL abandon the operation; remaining credit discarded.
REQ-035 A sensor held high across reset release SHALL NOT count as a coin... unless it falls and rises again.

Verification
REQ-036 coin_10, coin_5, sel_a -> credit 10, 15, disp_req=1 disp_item=0 credit 0; disp_done -> IDLE, no chg_pulse.
REQ-037 coin_10 x3, sel_b -> credit 30, DISPENSE credit 10; disp_done -> exactly 2 chg_pulse cycles, credit 0, IDLE.
REQ-038 coin_10 x3 then coin_5 -> coin_reject pulse, credit stays 30; simultaneous coin_5+coin_10 -> coin_reject, credit unchanged.
REQ-039 coin_5, sel_a -> ignored, state CREDIT; no further input for TIMEOUT cycles -> CHANGE, 1 chg_pulse, IDLE.
REQ-040 coin_10, cancel same cycle as sel_a with credit 20 -> CHANGE, 4 chg_pulse cycles, no disp_req.
REQ-041 reset asserted mid-CHANGE with credit 15 -> all outputs zero asynchronously, IDLE after release.
